// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB requester signals of the bridge.
// master = bridge view, slave = command source / APB completer view.
interface apb_master_bridge_if #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_write;
  logic [ADDRWIDTH-1:0] cmd_addr;
  logic [DATAWIDTH-1:0] cmd_wdata;
  logic                 rsp_valid;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: one command -> SETUP + ACCESS, rsp_valid pulse 3+ cycles after accept.
// cmd_ready only in IDLE; rsp has no backpressure; stuck completer aborts after TIMEOUT ACCESS cycles.
module apb_master_bridge #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc       = cnt + 1'b1;
  assign bus.cmd_ready = (state == IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.PSEL      <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PADDR     <= '0;
      bus.PWDATA    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.PWRITE  <= bus.cmd_write;
            bus.PADDR   <= bus.cmd_addr;
            bus.PWDATA  <= bus.cmd_wdata;
            bus.PSEL    <= 1'b1;
            bus.PENABLE <= 1'b0;
            cnt         <= '0;
            state       <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
          state       <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt_inc;
          // PREADY is tested first so a completion on the timeout edge still wins
          if (bus.PREADY) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= bus.PWRITE ? '0 : bus.PRDATA;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            state         <= IDLE;
          end else if (cnt_inc == CW'(TIMEOUT)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.PSEL      <= 1'b0;
            bus.PENABLE   <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.PSEL    <= 1'b0;
          bus.PENABLE <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a behavioural 256x32 APB RAM completer.
module tb_apb_master_bridge;
  localparam int DW = 32;
  localparam int AW = 8;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_bridge_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus();

  apb_master_bridge #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(16)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Completer: PREADY after wait_n ACCESS wait cycles; junk PRDATA while not ready
  logic [DW-1:0] mem [256];
  int  wait_n  = 0;
  int  acc_cnt = 0;
  bit  mem_init = 1'b0;
  always @(negedge PCLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem_init = 1'b1;
    end
    if (bus.PSEL && bus.PENABLE) begin
      if (acc_cnt >= wait_n) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = mem[bus.PADDR];
        if (bus.PWRITE) mem[bus.PADDR] = bus.PWDATA;
      end else begin
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hBAD0_BAD0;
      end
      acc_cnt++;
    end else begin
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h5A5A_0000;
      acc_cnt = 0;
    end
  end

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_cycles;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Called and returns at a negedge.
  task automatic run_cmd(input vec_t v);
    int lat;
    int nset;
    int nacc;
    bit unstable;
    wait_n        = v.wait_cycles;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    chk("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    lat = 0; nset = 0; nacc = 0; unstable = 1'b0;
    do begin
      @(negedge PCLK);
      lat++;
      if (bus.PSEL) begin
        if (bus.PENABLE) nacc++; else nset++;
        if (bus.PADDR !== v.addr || bus.PWRITE !== v.write) unstable = 1'b1;
        if (v.write && bus.PWDATA !== v.wdata) unstable = 1'b1;
      end
    end while (!bus.rsp_valid && lat < 40);
    chk("latency", lat, v.exp_lat);
    chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
    chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    chk("setup_cycles", nset, 32'd1);
    chk("access_cycles", nacc, v.exp_lat - 2);
    chk("addr_data_stable", {31'd0, unstable}, 32'd0);
    chk("cmd_ready_in_rsp", {31'd0, bus.cmd_ready}, 32'd1);
    chk("psel_low_in_rsp", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    @(negedge PCLK);
    chk("rsp_valid_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rsp_rdata_hold", bus.rsp_rdata, v.exp_rdata);
  endtask

  vec_t vecs[9];
  vec_t v;
  int   nrsp;
  int   last_rsp;
  int   idx;
  bit   psel_bad;
  int   guard;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF,   0, 32'h0,        1'b0,  3};
    vecs[1] = '{1'b0, 8'h10, 32'h0,          2, 32'hDEADBEEF, 1'b0,  5};
    vecs[2] = '{1'b0, 8'h10, 32'h0,        999, 32'h0,        1'b1, 18};
    vecs[3] = '{1'b1, 8'h20, 32'h12345678,   3, 32'h0,        1'b0,  6};
    vecs[4] = '{1'b0, 8'h20, 32'h0,          3, 32'h12345678, 1'b0,  6};
    vecs[5] = '{1'b1, 8'hFF, 32'hA5A5A5A5,   1, 32'h0,        1'b0,  4};
    vecs[6] = '{1'b0, 8'hFF, 32'h0,          0, 32'hA5A5A5A5, 1'b0,  3};
    vecs[7] = '{1'b0, 8'h20, 32'h0,         15, 32'h12345678, 1'b0, 18};
    vecs[8] = '{1'b0, 8'h10, 32'h0,         14, 32'hDEADBEEF, 1'b0, 17};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_psel_penable", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("reset_pwrite", {31'd0, bus.PWRITE}, 32'd0);
    chk("reset_paddr", {24'd0, bus.PADDR}, 32'd0);
    chk("reset_pwdata", bus.PWDATA, 32'd0);
    chk("reset_rsp", {30'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

    // Back-to-back writes with cmd_valid held high
    wait_n = 0;
    idx = 0; nrsp = 0; last_rsp = -1; psel_bad = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'd0;
    bus.cmd_wdata = 32'h100;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      if (bus.rsp_valid) begin
        nrsp++;
        last_rsp = cyc;
        if (bus.rsp_err) psel_bad = 1'b1;
      end
      if (cyc != 0 && !bus.PSEL && !bus.rsp_valid) psel_bad = 1'b1;
      if (bus.cmd_ready && bus.cmd_valid) begin
        @(posedge PCLK);
        #1;
        idx++;
        if (idx == 4) bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 8'(idx);
        bus.cmd_wdata = 32'h100 + 32'(idx);
      end
      @(negedge PCLK);
    end
    chk("b2b_responses", nrsp, 32'd4);
    chk("b2b_last_rsp_cycle", last_rsp, 32'd12);
    chk("b2b_psel_pattern", {31'd0, psel_bad}, 32'd0);
    chk("b2b_mem0", mem[0], 32'h100);
    chk("b2b_mem3", mem[3], 32'h103);

    // Reset asserted mid-ACCESS
    wait_n = 999;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h10;
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    guard = 0;
    while (!bus.PENABLE && guard < 10) begin
      @(negedge PCLK);
      guard++;
    end
    chk("rst_reached_access", {31'd0, bus.PENABLE}, 32'd1);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    chk("rst_async_psel_penable", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
    chk("rst_async_paddr", {24'd0, bus.PADDR}, 32'd0);
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) nrsp++;
      if (c == 2) PRESETn = 1'b1;
    end
    chk("rst_no_response", nrsp, 32'd0);
    chk("rst_idle_ready", {31'd0, bus.cmd_ready}, 32'd1);
    v = '{1'b1, 8'h40, 32'hCAFEF00D, 0, 32'h0, 1'b0, 3};
    run_cmd(v);
    v = '{1'b0, 8'h40, 32'h0, 1, 32'hCAFEF00D, 1'b0, 4};
    run_cmd(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
